interrupt_scheduler: RTL and testbench
======================================

// Module: interrupt_scheduler
// PURPOSE
//  Collects interrupt requests from N game-side sources (jump key, frame-ready, future inputs) and
//  serialises them onto the single 32-bit interrupt-instruction path into the CPU. Latches each request,
//  picks one winner, holds its instruction until the CPU acknowledges it, then enforces a gap.
//  Replaces ad-hoc one-cycle pulses, so no interrupt is lost when two sources fire together.
// PARAMETERS
//  N_SRC     4   number of request sources; index 0 = highest priority
//  GAP_CYC   2   idle cycles forced after each ack before the next grant (0 allowed)
//  DROP_W    8   width of the per-source saturating dropped-request counter
// PORTS
//  proc_clk        in   1        processor clock; the only clock
//  reset           in   1        synchronous, active-high reset
//  src_req         in   N_SRC    per-source request, sampled on every proc_clk edge; level-high = request
//  src_instr       in   32*N_SRC instruction word per source; slice i = bits [32*i+31:32*i]
//  cpu_ack         in   1        CPU has consumed interrupt_instruction; meaningful only while irq_valid=1
//  irq_valid       out  1        interrupt_instruction carries a live interrupt
//  interrupt_instruction out 32  granted source's word; 32'b0 whenever irq_valid=0
//  irq_src         out  $clog2(N_SRC) index of the granted source; 0 when idle
//  pending         out  N_SRC    latched, not-yet-served requests
//  drop_count      out  DROP_W*N_SRC per-source count of requests that arrived while already pending
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; pending=0; irq_valid=0; interrupt_instruction=0; irq_src=0;
//    drop_count=0; gap counter=0. Reset asserted mid-ISSUE drops the in-flight interrupt silently.
//  - Rising-edge detect: a request is a 0->1 transition of src_req[i] (previous-sample register, reset 0).
//    Holding src_req high does not generate repeated requests.
//  - Latch: on edge with rise[i]: pending[i]<=1. If pending[i] is already 1 and not being cleared this edge,
//    drop_count[i] increments, saturating at all-ones (no wrap).
//  - FSM states: IDLE, ISSUE, HOLDOFF.
//    IDLE: if pending!=0, grant winner w; at that edge irq_valid<=1, interrupt_instruction<=src_instr[w]
//      (captured, stable until ack even if src_instr changes), irq_src<=w, ->ISSUE. Else stay.
//    ISSUE: irq_valid=1. On edge with cpu_ack=1: irq_valid<=0, interrupt_instruction<=0, pending[w]<=0,
//      ->HOLDOFF if GAP_CYC>0 else IDLE. No ack: hold indefinitely.
//    HOLDOFF: count GAP_CYC edges, then ->IDLE. Requests keep latching throughout.
//  - Latency: rise sampled at edge E0 -> pending set at E0 -> irq_valid high after E1 (2nd edge).
//  - Simultaneous rise on granted source and cpu_ack on the same edge: the clear loses, pending[w] stays 1,
//    counts as a fresh request (no drop_count increment).
//  - cpu_ack while irq_valid=0: ignored.
//  - Arbitration (default): fixed priority, lowest index with pending=1 wins.
// CONFIGURATION
//  - IRQ_ROUND_ROBIN_EN defined: round-robin arbitration; a last-grant pointer (reset N_SRC-1) makes
//    the search start at (last+1) mod N_SRC; pointer updates on each grant.
//  - Undefined: fixed priority as above; no pointer register exists.
// STRUCTURE
//  - Shared package irq_pkg: FSM state encoding (IDLE/ISSUE/HOLDOFF), IRQ_NONE = 32'b0, and the
//    source-index constants (SRC_JUMP=0, SRC_FRAME=1) used by the instruction builders.
//  - One sub-module: irq_priority_pick (combinational; pending + start index -> winner index, any_valid).
//    The top holds edge-detect, pending/drop registers, FSM, gap counter and output registers.
// TESTING
//  1. Reset mid-ISSUE: grant src 1, assert reset one cycle -> irq_valid=0, instruction=0, pending=0 next edge.
//  2. Simultaneous: rise on src 0 and src 2 same edge, default build -> src 0 granted first, ack, 2 idle
//     cycles, then src 2 granted; instruction words match the src_instr slices exactly.
//  3. Hold without ack: grant src 1, leave cpu_ack=0 for 100 cycles while src_instr[1] changes
//     -> output word constant, irq_valid stays 1.
//  4. Drop saturation: DROP_W=2, pulse src 3 six times while it is pending -> drop_count[3]=3, no wrap.
//  5. Ack/rise collision: src 0 re-rises on the ack edge -> pending[0] stays 1, drop_count[0] unchanged,
//     re-granted after GAP_CYC.
//  6. IRQ_ROUND_ROBIN_EN: all 4 sources held pending, ack each grant -> order 0,1,2,3, then 0 again.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt scheduler: FSM encoding,
// the idle instruction word and the well-known source indices.
package irq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } irq_state_e;

  localparam logic [31:0] IRQ_NONE = 32'b0;

  localparam int SRC_JUMP  = 0;
  localparam int SRC_FRAME = 1;
endpackage

// File: rtl/interrupt_scheduler_if.sv
// CPU-facing interrupt handshake: scheduler (master) presents a word,
// CPU (slave) acknowledges it.
interface interrupt_scheduler_if #(
  parameter int N_SRC = 4
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic          cpu_ack;
  logic          irq_valid;
  logic [31:0]   interrupt_instruction;
  logic [IW-1:0] irq_src;

  modport master (input cpu_ack, output irq_valid, interrupt_instruction, irq_src);
  modport slave  (output cpu_ack, input irq_valid, interrupt_instruction, irq_src);
endinterface

// File: rtl/irq_priority_pick.sv
// Combinational winner select: first set bit of pending_i scanning upward
// from start_i, wrapping modulo N_SRC.
module irq_priority_pick #(
  parameter int N_SRC = 4,
  parameter int IW    = 2
) (
  input  logic [N_SRC-1:0] pending_i,
  input  logic [IW-1:0]    start_i,
  output logic [IW-1:0]    winner_o,
  output logic             any_o
);
  // Scan from the far end down so the smallest offset from start_i wins.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (pending_i[(int'(start_i) + k) % N_SRC]) begin
        winner_o = IW'((int'(start_i) + k) % N_SRC);
        any_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/interrupt_scheduler.sv
// Latches edge-detected interrupt requests and serialises them to the CPU.
// Define IRQ_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module interrupt_scheduler
  import irq_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int GAP_CYC = 2,
  parameter int DROP_W  = 8
) (
  input  logic                    proc_clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_req,
  input  logic [32*N_SRC-1:0]     src_instr,
  output logic [N_SRC-1:0]        pending,
  output logic [DROP_W*N_SRC-1:0] drop_count,
  interrupt_scheduler_if.master   cpu
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  logic [N_SRC-1:0]             req_q, pending_q, pending_d, rise, clr;
  logic [N_SRC-1:0][DROP_W-1:0] drop_q;
  irq_state_e                   state_q;
  logic [GW-1:0]                gap_q;
  logic                         valid_q;
  logic [31:0]                  instr_q;
  logic [IW-1:0]                src_q, start, win;
  logic                         any;

  assign rise = src_req & ~req_q;

  // A rise on the same edge as the ack re-arms the source instead of being lost.
  always_comb begin
    clr = '0;
    if (state_q == ST_ISSUE && cpu.cpu_ack) clr[src_q] = 1'b1;
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge proc_clk) begin
    if (reset) begin
      req_q     <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      req_q     <= src_req;
      pending_q <= pending_d;
      for (int i = 0; i < N_SRC; i++) begin
        if (rise[i] && pending_q[i] && !clr[i] && (drop_q[i] != '1))
          drop_q[i] <= drop_q[i] + 1'b1;
      end
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IW-1:0] last_q;
  assign start = (int'(last_q) == N_SRC - 1) ? '0 : last_q + 1'b1;
  always_ff @(posedge proc_clk) begin
    if (reset)                            last_q <= IW'(N_SRC - 1);
    else if (state_q == ST_IDLE && any)   last_q <= win;
  end
`else
  assign start = '0;
`endif

  irq_priority_pick #(.N_SRC(N_SRC), .IW(IW)) u_pick (
    .pending_i (pending_q),
    .start_i   (start),
    .winner_o  (win),
    .any_o     (any)
  );

  always_ff @(posedge proc_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      instr_q <= IRQ_NONE;
      src_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (any) begin
          valid_q <= 1'b1;
          instr_q <= src_instr[int'(win)*32 +: 32];
          src_q   <= win;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: if (cpu.cpu_ack) begin
          valid_q <= 1'b0;
          instr_q <= IRQ_NONE;
          src_q   <= '0;
          gap_q   <= '0;
          state_q <= (GAP_CYC > 0) ? ST_HOLDOFF : ST_IDLE;
        end
        ST_HOLDOFF: begin
          if (int'(gap_q) >= GAP_CYC - 1) state_q <= ST_IDLE;
          else                            gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pending                   = pending_q;
  assign drop_count                = drop_q;
  assign cpu.irq_valid             = valid_q;
  assign cpu.interrupt_instruction = instr_q;
  assign cpu.irq_src               = src_q;
endmodule

// File: tb/tb_interrupt_scheduler.sv
// Scoreboard bench for interrupt_scheduler: expected grants queued at stimulus,
// popped by a monitor on each rising irq_valid.
module tb_interrupt_scheduler;
  import irq_pkg::*;

  localparam int N = 4, GAP = 2, DW = 2;

  logic           proc_clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_req;
  logic [32*N-1:0] src_instr;
  logic [N-1:0]   pending;
  logic [DW*N-1:0] drop_count;
  logic [31:0]    words [N];

  interrupt_scheduler_if #(.N_SRC(N)) cpu_if ();

  interrupt_scheduler #(.N_SRC(N), .GAP_CYC(GAP), .DROP_W(DW)) dut (
    .proc_clk   (proc_clk),
    .reset      (reset),
    .src_req    (src_req),
    .src_instr  (src_instr),
    .pending    (pending),
    .drop_count (drop_count),
    .cpu        (cpu_if)
  );

  always #5 proc_clk = ~proc_clk;

  always @* begin
    src_instr = '0;
    for (int i = 0; i < N; i++) src_instr[32*i +: 32] = words[i];
  end

  typedef struct {
    logic [1:0]  src;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0, n_fail = 0;
  logic mon_en = 1'b0, prev_v = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge proc_clk); #1;
  endtask

  task automatic push(input int s);
    sb.push_back('{src: 2'(s), word: words[s]});
  endtask

  task automatic ack();
    cpu_if.cpu_ack = 1'b1; tick(); cpu_if.cpu_ack = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src_req = m; tick(); src_req = '0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_grant(input string tag, output int n);
    n = 0;
    while (!cpu_if.irq_valid && n < 20) begin tick(); n++; end
    if (!cpu_if.irq_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  always @(negedge proc_clk) begin
    if (mon_en) begin
      if (cpu_if.irq_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_grant", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("grant_src", 64'(cpu_if.irq_src), 64'(mon_e.src));
          chk("grant_word", 64'(cpu_if.interrupt_instruction), 64'(mon_e.word));
        end
      end
      if (!cpu_if.irq_valid)
        chk("idle_outputs", {cpu_if.irq_src, cpu_if.interrupt_instruction}, 0);
      prev_v = cpu_if.irq_valid;
    end
  end

  initial begin
    int n;
    logic [31:0] held;
    reset = 1'b1; src_req = '0; cpu_if.cpu_ack = 1'b0;
    words[SRC_JUMP]  = 32'hA0A0_0001;
    words[SRC_FRAME] = 32'hB1B1_0002;
    words[2]         = 32'hC2C2_0003;
    words[3]         = 32'hD3D3_0004;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 64'(cpu_if.irq_valid), 0);
    chk("rst_word", 64'(cpu_if.interrupt_instruction), 0);
    chk("rst_src", 64'(cpu_if.irq_src), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_drop", 64'(drop_count), 0);
    mon_en = 1'b1;

    // Latency, then reset while the interrupt is in flight
    push(SRC_FRAME);
    src_req = 4'b0010; tick();
    chk("lat_pending_e0", 64'(pending), 64'h2);
    chk("lat_valid_e0", 64'(cpu_if.irq_valid), 0);
    src_req = '0; tick();
    chk("lat_valid_e1", 64'(cpu_if.irq_valid), 1);
    tick();
    do_reset();
    chk("midrst_valid", 64'(cpu_if.irq_valid), 0);
    chk("midrst_word", 64'(cpu_if.interrupt_instruction), 0);
    chk("midrst_pending", 64'(pending), 0);
    tick(); tick();
    chk("midrst_no_regrant", 64'(cpu_if.irq_valid), 0);

    // Simultaneous rise on 0 and 2
    push(0); push(2);
    src_req = 4'b0101; tick(); src_req = '0;
    wait_grant("sim0", n);
    ack();
    chk("sim_pending_after_ack", 64'(pending), 64'h4);
    wait_grant("sim2", n);
    chk("sim_gap_cycles", 64'(n), 64'(GAP + 1));
    ack(); repeat (4) tick();

    // Hold without ack while the source word changes
    push(SRC_FRAME); held = words[SRC_FRAME];
    pulse(4'b0010);
    wait_grant("hold", n);
    for (int i = 0; i < 100; i++) begin
      words[SRC_FRAME] = $urandom; tick();
      if (i % 10 == 9) begin
        chk("hold_valid", 64'(cpu_if.irq_valid), 1);
        chk("hold_word", 64'(cpu_if.interrupt_instruction), 64'(held));
      end
    end
    ack(); repeat (4) tick();

    // Drop counter saturation on source 3
    push(3);
    pulse(4'b1000);
    wait_grant("drop", n);
    pulse(4'b1000); pulse(4'b1000);
    chk("drop_after2", 64'(drop_count[7:6]), 2);
    repeat (4) pulse(4'b1000);
    chk("drop_sat", 64'(drop_count[7:6]), 3);
    ack();
    chk("drop_pending_clr", 64'(pending), 0);
    repeat (4) tick();
    chk("drop_no_regrant", 64'(cpu_if.irq_valid), 0);

    // Ack / re-rise collision on source 0
    push(0);
    pulse(4'b0001);
    wait_grant("coll_a", n);
    push(0);
    src_req = 4'b0001; cpu_if.cpu_ack = 1'b1; tick();
    src_req = '0; cpu_if.cpu_ack = 1'b0;
    chk("coll_pending", 64'(pending), 1);
    chk("coll_drop", 64'(drop_count[1:0]), 0);
    wait_grant("coll_b", n);
    chk("coll_gap_cycles", 64'(n), 64'(GAP + 1));
    ack(); repeat (4) tick();

    // All four pending, source 0 re-requests while source 1 is served
    do_reset();
`ifdef IRQ_ROUND_ROBIN_EN
    push(0); push(1); push(2); push(3); push(0);
`else
    push(0); push(1); push(0); push(2); push(3);
`endif
    src_req = 4'b1111; tick(); src_req = '0;
    wait_grant("arb0", n); ack();
    wait_grant("arb1", n);
    pulse(4'b0001);
    ack();
    for (int k = 0; k < 3; k++) begin
      wait_grant("arbn", n); ack();
    end
    repeat (4) tick();
    chk("sb_empty", 64'(sb.size()), 0);
    chk("final_pending", 64'(pending), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
